// File: rtl/sejf_pkg.sv
// Shared types and helpers for the sejf quadrature encoder path.
// Holds the encoder FSM states, direction codes and quadrature phase mapping.
package sejf_pkg;

  localparam int unsigned PHASE_W = 2;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_HOLD  = 2'd2
  } enc_state_e;

  // Gray-style phase index to {a,b}; consecutive indices differ in one bit.
  function automatic logic [1:0] phase_ab(input logic [PHASE_W-1:0] p);
    logic [1:0] ab;
    case (p)
      2'd0:    ab = 2'b00;
      2'd1:    ab = 2'b10;
      2'd2:    ab = 2'b11;
      default: ab = 2'b01;
    endcase
    return ab;
  endfunction

  function automatic logic [PHASE_W-1:0] phase_step(input logic [PHASE_W-1:0] p,
                                                    input logic dir);
    return (dir == DIR_DOWN) ? p - PHASE_W'(1) : p + PHASE_W'(1);
  endfunction

endpackage

// File: rtl/quad_knob_encoder_if.sv
// Command and quadrature-output bundle of the quadrature encoder.
interface quad_knob_encoder_if;
  logic step;
  logic up;
  logic ready;
  logic a;
  logic b;
  logic busy;
  logic dirch;
  logic done;

  modport master (output step, output up,
                  input ready, input a, input b, input busy, input dirch, input done);

  modport slave  (input step, input up,
                  output ready, output a, output b, output busy, output dirch, output done);
endinterface

// File: rtl/dir_fifo.sv
// Shift-register FIFO of 1-bit direction entries; head is always entry 0.
module dir_fifo #(
  parameter  int unsigned DEPTH = 3,
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          din,
  input  logic          pop,
  output logic          head,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full
);
  logic [DEPTH-1:0] mem, mem_n;
  logic [CW-1:0]    count_n;
  logic [CW-1:0]    wr_idx;
  logic             do_push, do_pop;

  assign head = mem[0];

  // A simultaneous pop shifts first, so the write lands one slot lower.
  always_comb begin
    do_push = push && !full;
    do_pop  = pop && !empty;
    mem_n   = mem;
    if (do_pop) begin
      mem_n = mem >> 1;
    end
    wr_idx = do_pop ? count - CW'(1) : count;
    if (do_push) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (CW'(i) == wr_idx) begin
          mem_n[i] = din;
        end
      end
    end
    count_n = count + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem   <= '0;
      count <= '0;
      empty <= 1'b1;
      full  <= 1'b0;
    end else begin
      mem   <= mem_n;
      count <= count_n;
      empty <= (count_n == '0);
      full  <= (count_n == CW'(DEPTH));
    end
  end

endmodule

// File: rtl/quad_knob_encoder.sv
// Quadrature emulator: turns queued single-detent step commands into the
// A/B phase sequence a mechanical rotary control would produce.
module quad_knob_encoder
  import sejf_pkg::*;
#(
  parameter int unsigned DWELL  = 4,
  parameter int unsigned EDGES  = 4,
  parameter int unsigned QDEPTH = 3
) (
  input logic                clk,
  input logic                rst,
  quad_knob_encoder_if.slave kif
);
  localparam int unsigned DW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int unsigned EW = $clog2(EDGES + 1);
  localparam int unsigned CW = $clog2(QDEPTH + 1);

  enc_state_e         state, state_n;
  logic [PHASE_W-1:0] p, p_n;
  logic               cur_dir, cur_dir_n;
  logic               last_dir, last_dir_n;
  logic [DW-1:0]      dwell, dwell_n;
  logic [EW-1:0]      edge_cnt, edge_cnt_n;
  logic               dirch_n, done_n;
  logic               a_q, b_q, busy_q, dirch_q, done_q;

  logic               pop_c;
  logic               fifo_head, fifo_empty, fifo_full;
  logic [CW-1:0]      fifo_count;

  dir_fifo #(.DEPTH(QDEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (kif.step),
    .din   (kif.up),
    .pop   (pop_c),
    .head  (fifo_head),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign kif.ready = !fifo_full;
  assign kif.a     = a_q;
  assign kif.b     = b_q;
  assign kif.busy  = busy_q;
  assign kif.dirch = dirch_q;
  assign kif.done  = done_q;

  // Next-state logic; the final dwell of a detent may pop the next command directly.
  always_comb begin
    state_n    = state;
    p_n        = p;
    cur_dir_n  = cur_dir;
    last_dir_n = last_dir;
    dwell_n    = dwell;
    edge_cnt_n = edge_cnt;
    dirch_n    = 1'b0;
    done_n     = 1'b0;
    pop_c      = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop_c     = 1'b1;
          cur_dir_n = fifo_head;
          state_n   = ST_START;
        end
      end

      ST_START: begin
        p_n        = phase_step(p, cur_dir);
        dirch_n    = (cur_dir != last_dir);
        last_dir_n = cur_dir;
        dwell_n    = DW'(DWELL - 1);
        edge_cnt_n = EW'(1);
        state_n    = ST_HOLD;
      end

      ST_HOLD: begin
        if (dwell != '0) begin
          dwell_n = dwell - DW'(1);
        end else if (edge_cnt < EW'(EDGES)) begin
          p_n        = phase_step(p, cur_dir);
          dwell_n    = DW'(DWELL - 1);
          edge_cnt_n = edge_cnt + EW'(1);
        end else begin
          done_n = 1'b1;
          if (!fifo_empty) begin
            pop_c     = 1'b1;
            cur_dir_n = fifo_head;
            state_n   = ST_START;
          end else begin
            state_n = ST_IDLE;
          end
        end
      end

      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      p        <= '0;
      cur_dir  <= DIR_UP;
      last_dir <= DIR_UP;
      dwell    <= '0;
      edge_cnt <= '0;
      a_q      <= 1'b0;
      b_q      <= 1'b0;
      busy_q   <= 1'b0;
      dirch_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state      <= state_n;
      p          <= p_n;
      cur_dir    <= cur_dir_n;
      last_dir   <= last_dir_n;
      dwell      <= dwell_n;
      edge_cnt   <= edge_cnt_n;
      {a_q, b_q} <= phase_ab(p_n);
      busy_q     <= (state_n != ST_IDLE);
      dirch_q    <= dirch_n;
      done_q     <= done_n;
    end
  end

  count_bound: assert property (@(posedge clk) disable iff (rst) fifo_count <= CW'(QDEPTH));

endmodule
